// File: rtl/hawk_pkg.sv
// Shared disk-emulator types and default field geometry for the sector read/write paths.
// Pure declarations: no latency and no flow control.
package hawk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_GAP,
    ADDR,
    DATA_GAP,
    DATA,
    END_GAP
  } sector_pos_t;

  typedef enum logic [1:0] {
    HUNT,
    SHIFT,
    DONE
  } cap_state_t;

  localparam int ADDR_GAP_LEN_DEF = 208;
  localparam int ADDR_LEN_DEF     = 32;
  localparam int DATA_GAP_LEN_DEF = 208;
  localparam int DATA_LEN_DEF     = 408;
  localparam int DATA_BYTES_DEF   = DATA_LEN_DEF / 8;

  // Wide enough for the longest field and for a byte index up to DATA_BYTES.
  localparam int CNT_W = 9;

endpackage

// File: rtl/sector_timer.sv
// Per-sector bit-position tracker: strobe on cycle T gives ADDR_GAP/count 0 on T+1.
// No backpressure: it advances one bit per clock, and a strobe always restarts it.
module sector_timer
  import hawk_pkg::*;
#(
  parameter int ADDR_GAP_LEN = ADDR_GAP_LEN_DEF,
  parameter int ADDR_LEN     = ADDR_LEN_DEF,
  parameter int DATA_GAP_LEN = DATA_GAP_LEN_DEF,
  parameter int DATA_LEN     = DATA_LEN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sector_strobe,
  output sector_pos_t pos,
  output logic        field_end
);

  sector_pos_t            pos_q, pos_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       cur_len;

  always_comb begin
    cur_len = '0;
    case (pos_q)
      ADDR_GAP: cur_len = CNT_W'(ADDR_GAP_LEN);
      ADDR:     cur_len = CNT_W'(ADDR_LEN);
      DATA_GAP: cur_len = CNT_W'(DATA_GAP_LEN);
      DATA:     cur_len = CNT_W'(DATA_LEN);
      default:  cur_len = '0;
    endcase
  end

  // IDLE and END_GAP have no length, so they never report a field end.
  assign field_end = (cur_len != '0) && (cnt_q == cur_len - 1'b1);
  assign pos       = pos_q;

  always_comb begin
    pos_d = pos_q;
    cnt_d = cnt_q;
    if (sector_strobe) begin
      pos_d = ADDR_GAP;
      cnt_d = '0;
    end else if (field_end) begin
      cnt_d = '0;
      case (pos_q)
        ADDR_GAP: pos_d = ADDR;
        ADDR:     pos_d = DATA_GAP;
        DATA_GAP: pos_d = DATA;
        DATA:     pos_d = END_GAP;
        default:  pos_d = pos_q;
      endcase
    end else if (cur_len != '0) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= IDLE;
      cnt_q <= '0;
    end else begin
      pos_q <= pos_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sector_write.sv
// Sector write deserializer: sync bit on S gives buf_we on S+9, then every 8 cycles; optional SECTOR_WRITE_PROTECT_EN adds wr_protect.
// No backpressure: the serial stream is consumed one bit per clock and buffer writes are fire-and-forget.
module sector_write
  import hawk_pkg::*;
#(
  parameter int ADDR_GAP_LEN = ADDR_GAP_LEN_DEF,
  parameter int ADDR_LEN     = ADDR_LEN_DEF,
  parameter int DATA_GAP_LEN = DATA_GAP_LEN_DEF,
  parameter int DATA_LEN     = DATA_LEN_DEF,
  parameter int DATA_BYTES   = DATA_BYTES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sector_strobe,
  input  logic       wr_gate,
  input  logic       wr_data,
`ifdef SECTOR_WRITE_PROTECT_EN
  input  logic       wr_protect,
`endif
  output logic [8:0] buf_addr,
  output logic [7:0] buf_data,
  output logic       buf_we,
  output logic       sector_done,
  output logic [8:0] byte_count,
  output logic       fault
);

  localparam logic [CNT_W-1:0] BYTES_MAX = CNT_W'(DATA_BYTES);

  sector_pos_t pos;
  logic        field_end;
  logic        protect;

  sector_timer #(
    .ADDR_GAP_LEN (ADDR_GAP_LEN),
    .ADDR_LEN     (ADDR_LEN),
    .DATA_GAP_LEN (DATA_GAP_LEN),
    .DATA_LEN     (DATA_LEN)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .sector_strobe (sector_strobe),
    .pos           (pos),
    .field_end     (field_end)
  );

`ifdef SECTOR_WRITE_PROTECT_EN
  assign protect = wr_protect;
`else
  assign protect = 1'b0;
`endif

  cap_state_t       cap_q, cap_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [6:0]       sh_q, sh_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [8:0]       buf_addr_q, buf_addr_d;
  logic [7:0]       buf_data_q, buf_data_d;
  logic             buf_we_q, buf_we_d;
  logic             sector_done_q, sector_done_d;
  logic [8:0]       byte_count_q, byte_count_d;
  logic             fault_q, fault_d;

  always_comb begin
    cap_d         = cap_q;
    bit_cnt_d     = bit_cnt_q;
    sh_d          = sh_q;
    idx_d         = idx_q;
    buf_addr_d    = buf_addr_q;
    buf_data_d    = buf_data_q;
    buf_we_d      = 1'b0;
    sector_done_d = 1'b0;
    byte_count_d  = byte_count_q;
    fault_d       = fault_q;

    // A strobe restarts the sector and silently drops any byte in flight.
    if (sector_strobe) begin
      cap_d     = HUNT;
      bit_cnt_d = '0;
      idx_d     = '0;
      fault_d   = 1'b0;
    end else begin
      case (cap_q)
        HUNT: begin
          if ((pos == DATA_GAP || pos == DATA) && wr_gate && wr_data) begin
            cap_d     = SHIFT;
            bit_cnt_d = '0;
          end
        end
        SHIFT: begin
          if (!wr_gate) begin
            cap_d = DONE;
          end else begin
            sh_d      = {sh_q[5:0], wr_data};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              buf_data_d = {sh_q, wr_data};
              buf_addr_d = idx_q;
              buf_we_d   = !protect;
              if (idx_q < BYTES_MAX) idx_d = idx_q + 1'b1;
              if (idx_q + 1'b1 >= BYTES_MAX) cap_d = DONE;
            end
          end
        end
        default: cap_d = cap_q;
      endcase

      if (wr_gate && (pos == ADDR_GAP || pos == ADDR || protect)) fault_d = 1'b1;

      // Still shifting with the gate up as DATA ends means the write overran the field.
      if (pos == DATA && field_end) begin
        sector_done_d = 1'b1;
        byte_count_d  = idx_d;
        if (cap_q == SHIFT && wr_gate) fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q         <= HUNT;
      bit_cnt_q     <= '0;
      sh_q          <= '0;
      idx_q         <= '0;
      buf_addr_q    <= '0;
      buf_data_q    <= '0;
      buf_we_q      <= 1'b0;
      sector_done_q <= 1'b0;
      byte_count_q  <= '0;
      fault_q       <= 1'b0;
    end else begin
      cap_q         <= cap_d;
      bit_cnt_q     <= bit_cnt_d;
      sh_q          <= sh_d;
      idx_q         <= idx_d;
      buf_addr_q    <= buf_addr_d;
      buf_data_q    <= buf_data_d;
      buf_we_q      <= buf_we_d;
      sector_done_q <= sector_done_d;
      byte_count_q  <= byte_count_d;
      fault_q       <= fault_d;
    end
  end

  assign buf_addr    = buf_addr_q;
  assign buf_data    = buf_data_q;
  assign buf_we      = buf_we_q;
  assign sector_done = sector_done_q;
  assign byte_count  = byte_count_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_sector_write.sv
// Bench for sector_write: directed sectors, expected writes/completions queued and checked by a monitor.
module tb_sector_write;
  import hawk_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       sector_strobe;
  logic       wr_gate;
  logic       wr_data;
  logic [8:0] buf_addr;
  logic [7:0] buf_data;
  logic       buf_we;
  logic       sector_done;
  logic [8:0] byte_count;
  logic       fault;
`ifdef SECTOR_WRITE_PROTECT_EN
  logic       wr_protect = 1'b0;
`endif

  sector_write dut (
    .clk           (clk),
    .rst           (rst),
    .sector_strobe (sector_strobe),
    .wr_gate       (wr_gate),
    .wr_data       (wr_data),
`ifdef SECTOR_WRITE_PROTECT_EN
    .wr_protect    (wr_protect),
`endif
    .buf_addr      (buf_addr),
    .buf_data      (buf_data),
    .buf_we        (buf_we),
    .sector_done   (sector_done),
    .byte_count    (byte_count),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic [8:0] addr;
    logic [7:0] data;
  } wr_exp_t;

  typedef struct {
    int         cyc;
    logic [8:0] cnt;
  } done_exp_t;

  wr_exp_t   wr_q[$];
  done_exp_t done_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or a sector completion.
  logic we_prev = 1'b0;
  always @(negedge clk) begin
    wr_exp_t   we;
    done_exp_t de;
    if (!rst) begin
      if (buf_we) begin
        check("we_not_back_to_back", {31'b0, we_prev}, 32'd0);
        if (wr_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_we: got write addr %0d data 0x%0h at cycle %0d, expected none", buf_addr, buf_data, cyc);
        end else begin
          we = wr_q.pop_front();
          check("we_cycle", cyc, we.cyc);
          check("we_addr", {23'b0, buf_addr}, {23'b0, we.addr});
          check("we_data", {24'b0, buf_data}, {24'b0, we.data});
        end
      end
      if (sector_done) begin
        if (done_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got sector_done count %0d at cycle %0d, expected none", byte_count, cyc);
        end else begin
          de = done_q.pop_front();
          check("done_cycle", cyc, de.cyc);
          check("done_count", {23'b0, byte_count}, {23'b0, de.cnt});
        end
      end
    end
    we_prev = buf_we && !rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_strobe(output int t);
    t = cyc;
    sector_strobe = 1'b1;
    tick();
    sector_strobe = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      wr_data = b[i];
      tick();
    end
  endtask

  task automatic push_wr(input int c, input logic [8:0] a, input logic [7:0] d);
    wr_exp_t e;
    e.cyc = c; e.addr = a; e.data = d;
    wr_q.push_back(e);
  endtask

  task automatic push_done(input int c, input logic [8:0] n);
    done_exp_t e;
    e.cyc = c; e.cnt = n;
    done_q.push_back(e);
  endtask

  initial begin
    #150000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, s;
    logic [3:0] tail;
    logic [7:0] b;
    rst = 1'b1;
    sector_strobe = 1'b0;
    wr_gate = 1'b0;
    wr_data = 1'b0;
    #1;
    check("rst_buf_addr", {23'b0, buf_addr}, 32'd0);
    check("rst_buf_data", {24'b0, buf_data}, 32'd0);
    check("rst_buf_we", {31'b0, buf_we}, 32'd0);
    check("rst_sector_done", {31'b0, sector_done}, 32'd0);
    check("rst_byte_count", {23'b0, byte_count}, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    check("rst_pos", {29'b0, dut.pos}, {29'b0, IDLE});
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Two bytes after 16 preamble zeros in DATA_GAP.
    do_strobe(t);
    check("strobe_pos", {29'b0, dut.pos}, {29'b0, ADDR_GAP});
    idle_until(t + 241);
    wr_gate = 1'b1;
    wr_data = 1'b0;
    repeat (16) tick();
    s = cyc;
    push_wr(s + 9, 9'd0, 8'hA5);
    push_wr(s + 17, 9'd1, 8'h3C);
    push_done(t + 857, 9'd2);
    wr_data = 1'b1;
    tick();
    send_byte(8'hA5);
    send_byte(8'h3C);
    wr_gate = 1'b0;
    wr_data = 1'b0;
    idle_until(t + 860);
    check("t1_fault", {31'b0, fault}, 32'd0);

    // Sync on the last DATA_GAP bit, then 60 bytes: 51 captured, overrun fault.
    do_strobe(t);
    idle_until(t + 448);
    wr_gate = 1'b1;
    s = cyc;
    for (int i = 0; i < 51; i++) push_wr(s + 9 + 8 * i, 9'(i), 8'(8'h10 + i));
    push_done(t + 857, 9'd51);
    wr_data = 1'b1;
    tick();
    for (int i = 0; i < 60; i++) begin
      send_byte(8'(8'h10 + i));
      if (i == 49) check("t2_fault_before_exit", {31'b0, fault}, 32'd0);
      if (i == 50) check("t2_fault_after_exit", {31'b0, fault}, 32'd1);
    end
    wr_gate = 1'b0;
    wr_data = 1'b0;
    tick();

    // Gate raised in the address field.
    do_strobe(t);
    check("t3_fault_cleared", {31'b0, fault}, 32'd0);
    idle_until(t + 209);
    wr_gate = 1'b1;
    repeat (6) tick();
    wr_gate = 1'b0;
    tick();
    check("t3_fault_addr_gate", {31'b0, fault}, 32'd1);
    push_done(t + 857, 9'd0);
    idle_until(t + 860);
    check("t3_fault_sticky", {31'b0, fault}, 32'd1);

    // One byte then three stray bits before the gate drops.
    do_strobe(t);
    check("t4_fault_cleared", {31'b0, fault}, 32'd0);
    idle_until(t + 241);
    wr_gate = 1'b1;
    wr_data = 1'b0;
    repeat (4) tick();
    s = cyc;
    push_wr(s + 9, 9'd0, 8'h5A);
    push_done(t + 857, 9'd1);
    wr_data = 1'b1;
    tick();
    send_byte(8'h5A);
    tail = 4'b1010;
    for (int i = 3; i >= 1; i--) begin
      wr_data = tail[i];
      tick();
    end
    wr_gate = 1'b0;
    wr_data = 1'b0;
    idle_until(t + 860);
    check("t4_fault", {31'b0, fault}, 32'd0);

    // Strobe arrives four bits into a byte.
    do_strobe(t);
    idle_until(t + 441);
    wr_gate = 1'b1;
    wr_data = 1'b1;
    tick();
    b = 8'b1011_0000;
    for (int i = 7; i >= 4; i--) begin
      wr_data = b[i];
      tick();
    end
    t2 = cyc;
    sector_strobe = 1'b1;
    tick();
    sector_strobe = 1'b0;
    wr_gate = 1'b0;
    wr_data = 1'b0;
    check("t5_pos_restart", {29'b0, dut.pos}, {29'b0, ADDR_GAP});
    check("t5_fault", {31'b0, fault}, 32'd0);
    push_done(t2 + 857, 9'd0);
    idle_until(t2 + 860);

    // Asynchronous reset mid-capture.
    do_strobe(t);
    idle_until(t + 441);
    wr_gate = 1'b1;
    s = cyc;
    push_wr(s + 9, 9'd0, 8'hFF);
    wr_data = 1'b1;
    tick();
    send_byte(8'hFF);
    repeat (2) tick();
    check("t6_pre_rst_data", {24'b0, buf_data}, 32'hFF);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_buf_data", {24'b0, buf_data}, 32'd0);
    check("t6_rst_buf_addr", {23'b0, buf_addr}, 32'd0);
    check("t6_rst_buf_we", {31'b0, buf_we}, 32'd0);
    check("t6_rst_done", {31'b0, sector_done}, 32'd0);
    check("t6_rst_count", {23'b0, byte_count}, 32'd0);
    check("t6_rst_fault", {31'b0, fault}, 32'd0);
    check("t6_rst_pos", {29'b0, dut.pos}, {29'b0, IDLE});
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 900; i++) begin
      wr_data = i[0] ^ i[2];
      tick();
    end
    wr_gate = 1'b0;
    wr_data = 1'b0;
    check("t6_idle_pos", {29'b0, dut.pos}, {29'b0, IDLE});
    check("t6_idle_fault", {31'b0, fault}, 32'd0);

    repeat (4) tick();
    check("wr_queue_drained", wr_q.size(), 32'd0);
    check("done_queue_drained", done_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
